// File: rtl/tick_fifo_sequencer.sv
// Tick-driven fill/drain sequencer for an external FIFO.
// Define TICK_FIFO_DROP_CNT_EN to build the saturating dropped-tick counter.
module tick_fifo_sequencer #(
  parameter int TICK_DIV   = 50000000,
  parameter int DATA_W     = 8,
  parameter int CNT_W      = 7,
  parameter int FILL_LEVEL = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              fifo_full,
  input  logic              fifo_empty,
  input  logic [CNT_W-1:0]  fifo_data_count,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic [DATA_W-1:0] fifo_din,
  output logic              wr_en,
  output logic              rd_en,
  output logic              one_second_tick,
  output logic              one_second_pulse,
  output logic [DATA_W-1:0] count,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic [1:0]        state_dbg,
  output logic [7:0]        dropped_ticks
);

  localparam int DIV_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BURST_W = $clog2(FILL_LEVEL + 1);
  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(TICK_DIV - 1);
  localparam logic [BURST_W-1:0] BURST_FULL = BURST_W'(FILL_LEVEL);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [DIV_W-1:0]   div_q;
  logic               div_last;
  logic               tick_q;
  logic               pulse_q;
  logic [DATA_W-1:0]  count_q;
  logic [DATA_W-1:0]  din_q;
  logic               wr_q;
  logic [BURST_W-1:0] burst_q;
  logic               burst_done;
  logic               write_go;
  logic               rd_go;
  logic               rd_q;
  logic               valid_q;
  logic [DATA_W-1:0]  data_q;
  logic               status_unused;

  assign div_last   = (div_q == DIV_LAST);
  assign burst_done = (burst_q == BURST_FULL);

  // Occupancy is a debug mirror only; control relies on the flags.
  assign status_unused = ^fifo_data_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q   <= '0;
      tick_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      tick_q  <= div_last;
      pulse_q <= pulse_q ^ div_last;
      div_q   <= div_last ? '0 : div_q + 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    write_go = 1'b0;
    rd_go    = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) state_d = FILL;
      end
      FILL: begin
        write_go = tick_q && !burst_done && !fifo_full;
        if (burst_done)   state_d = DRAIN;
        else if (!enable) state_d = IDLE;
      end
      DRAIN: begin
        rd_go = !fifo_empty && !reset;
        if (fifo_empty) state_d = enable ? FILL : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q    <= 1'b0;
      din_q   <= '0;
      count_q <= '0;
      burst_q <= '0;
    end else begin
      wr_q <= write_go;
      if (write_go) begin
        din_q   <= count_q;
        count_q <= count_q + 1'b1;
        burst_q <= burst_q + 1'b1;
      end else if (state_q == FILL && burst_done) begin
        burst_q <= '0;
      end
    end
  end

  // FIFO data lands a cycle after rd_en, so capture trails by one stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q    <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      rd_q    <= rd_go;
      valid_q <= rd_q;
      if (rd_q) data_q <= fifo_dout;
    end
  end

`ifdef TICK_FIFO_DROP_CNT_EN
  logic       drop;
  logic [7:0] drop_q;

  assign drop = tick_q &&
    ((state_q == FILL && (burst_done || fifo_full)) ||
     state_q == DRAIN);

  always_ff @(posedge clk) begin
    if (reset)                      drop_q <= '0;
    else if (drop && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
  end

  assign dropped_ticks = drop_q;
`else
  assign dropped_ticks = '0;
`endif

  assign wr_en            = wr_q && !reset;
  assign rd_en            = rd_go;
  assign fifo_din         = din_q;
  assign count            = count_q;
  assign one_second_tick  = tick_q;
  assign one_second_pulse = pulse_q;
  assign out_data         = data_q;
  assign out_valid        = valid_q;
  assign state_dbg        = state_q;

endmodule

// File: tb/tb_tick_fifo_sequencer.sv
// Directed bench for tick_fifo_sequencer with a FIFO model and
// an output scoreboard fed by the expected write sequence.
module tb_tick_fifo_sequencer;

  localparam int TICK_DIV   = 4;
  localparam int DATA_W     = 8;
  localparam int CNT_W      = 7;
  localparam int FILL_LEVEL = 4;
  localparam int DEPTH      = 64;
`ifdef TICK_FIFO_DROP_CNT_EN
  localparam int EXP_DROP = 3;
`else
  localparam int EXP_DROP = 0;
`endif

  logic              clk;
  logic              reset;
  logic              enable;
  logic              force_full;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_data_count;
  logic [DATA_W-1:0] fifo_dout;
  logic [DATA_W-1:0] fifo_din;
  logic              wr_en;
  logic              rd_en;
  logic              one_second_tick;
  logic              one_second_pulse;
  logic [DATA_W-1:0] count;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic [1:0]        state_dbg;
  logic [7:0]        dropped_ticks;

  int n_cmp = 0;
  int n_bad = 0;
  int wr_total = 0;
  int out_total = 0;
  logic [7:0] exp_cnt = 8'd0;
  logic [7:0] out_q[$];

  tick_fifo_sequencer #(
    .TICK_DIV(TICK_DIV),
    .DATA_W(DATA_W),
    .CNT_W(CNT_W),
    .FILL_LEVEL(FILL_LEVEL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .fifo_full(fifo_full),
    .fifo_empty(fifo_empty),
    .fifo_data_count(fifo_data_count),
    .fifo_dout(fifo_dout),
    .fifo_din(fifo_din),
    .wr_en(wr_en),
    .rd_en(rd_en),
    .one_second_tick(one_second_tick),
    .one_second_pulse(one_second_pulse),
    .count(count),
    .out_data(out_data),
    .out_valid(out_valid),
    .state_dbg(state_dbg),
    .dropped_ticks(dropped_ticks)
  );

  // FIFO model: registered read data, one cycle after rd_en.
  logic [7:0] mem [DEPTH];
  logic [5:0] wp;
  logic [5:0] rp;
  logic [6:0] fcnt;
  logic       m_full;
  logic       m_empty;
  logic       wr_ok;
  logic       rd_ok;

  assign m_full          = (fcnt == 7'(DEPTH));
  assign m_empty         = (fcnt == 7'd0);
  assign wr_ok           = wr_en && !m_full;
  assign rd_ok           = rd_en && !m_empty;
  assign fifo_full       = m_full || force_full;
  assign fifo_empty      = m_empty;
  assign fifo_data_count = fcnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      wp        <= '0;
      rp        <= '0;
      fcnt      <= '0;
      fifo_dout <= '0;
    end else begin
      if (wr_ok) begin
        mem[wp] <= fifo_din;
        wp      <= wp + 6'd1;
      end
      if (rd_ok) begin
        fifo_dout <= mem[rp];
        rp        <= rp + 6'd1;
      end
      fcnt <= fcnt + 7'(wr_ok) - 7'(rd_ok);
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_writes(input int target, input int budget,
                             input string tag);
    int n = 0;
    while (wr_total < target && n < budget) begin
      cyc();
      n++;
    end
    chk(tag, 32'(wr_total >= target), 32'd1);
  endtask

  task automatic wait_state(input logic [1:0] s, input int budget,
                            input string tag);
    int n = 0;
    while (state_dbg !== s && n < budget) begin
      cyc();
      n++;
    end
    chk(tag, 32'(state_dbg), 32'(s));
  endtask

  task automatic wait_leave(input logic [1:0] s, input int budget,
                            input string tag);
    int n = 0;
    while (state_dbg === s && n < budget) begin
      cyc();
      n++;
    end
    chk(tag, 32'(state_dbg !== s), 32'd1);
  endtask

  // Monitor: write scoreboard and output scoreboard.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("wr_rd_excl", 32'(wr_en && rd_en), 32'd0);
        if (wr_en) begin
          chk("fifo_din", 32'(fifo_din), 32'(exp_cnt));
          out_q.push_back(exp_cnt);
          exp_cnt = exp_cnt + 8'd1;
          wr_total++;
        end
        if (out_valid) begin
          out_total++;
          if (out_q.size() == 0) begin
            chk("out_extra", 32'd1, 32'd0);
          end else begin
            e = out_q.pop_front();
            chk("out_data", 32'(out_data), 32'(e));
          end
        end
      end
    end
  end

  initial begin
    reset      = 1'b1;
    enable     = 1'b0;
    force_full = 1'b0;
    repeat (5) cyc();
    chk("rst_state", 32'(state_dbg), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_tick", 32'(one_second_tick), 32'd0);
    chk("rst_pulse", 32'(one_second_pulse), 32'd0);
    chk("rst_wr", 32'(wr_en), 32'd0);
    chk("rst_rd", 32'(rd_en), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_drop", 32'(dropped_ticks), 32'd0);

    // First burst and drain, cycle-exact.
    reset  = 1'b0;
    enable = 1'b1;
    for (int k = 1; k <= 23; k++) begin
      cyc();
      chk("tick", 32'(one_second_tick), 32'((k % 4) == 0));
      if (k == 1)  chk("idle_to_fill", 32'(state_dbg), 32'd1);
      if (k == 4)  chk("pulse_hi", 32'(one_second_pulse), 32'd1);
      if (k == 8)  chk("pulse_lo", 32'(one_second_pulse), 32'd0);
      if (k == 17) chk("fill_last", 32'(state_dbg), 32'd1);
      if (k == 17) chk("writes4", 32'(wr_total), 32'd4);
      if (k == 18) chk("to_drain", 32'(state_dbg), 32'd2);
      if (k == 18) chk("count4", 32'(count), 32'd4);
      if (k >= 18 && k <= 21) chk("rd_run", 32'(rd_en), 32'd1);
      if (k == 22) chk("rd_stop", 32'(rd_en), 32'd0);
      if (k == 22) chk("drain_hold", 32'(state_dbg), 32'd2);
      if (k == 23) chk("drain_to_fill", 32'(state_dbg), 32'd1);
      if (k == 23) chk("outs4", 32'(out_total), 32'd4);
    end
    wait_writes(5, 10, "write4_to");
    chk("count5", 32'(count), 32'd5);

    // Abort mid-drain with two words still queued.
    wait_state(2'd2, 40, "drain2_to");
    cyc();
    cyc();
    reset = 1'b1;
    out_q.delete();
    exp_cnt   = 8'd0;
    wr_total  = 0;
    out_total = 0;
    #1;
    chk("abort_rd_now", 32'(rd_en), 32'd0);
    cyc();
    chk("abort_state", 32'(state_dbg), 32'd0);
    chk("abort_rd", 32'(rd_en), 32'd0);
    chk("abort_count", 32'(count), 32'd0);
    chk("abort_pulse", 32'(one_second_pulse), 32'd0);
    chk("abort_valid", 32'(out_valid), 32'd0);
    repeat (4) cyc();

    // Full FIFO across three ticks.
    reset      = 1'b0;
    enable     = 1'b1;
    force_full = 1'b1;
    repeat (13) cyc();
    chk("full_nowr", 32'(wr_total), 32'd0);
    chk("full_count", 32'(count), 32'd0);
    chk("full_drop", 32'(dropped_ticks), 32'(EXP_DROP));
    force_full = 1'b0;

    // Pause mid-burst, then resume.
    wait_writes(2, 20, "en_w2_to");
    enable = 1'b0;
    cyc();
    chk("en_off_idle", 32'(state_dbg), 32'd0);
    repeat (12) cyc();
    chk("idle_nowr", 32'(wr_total), 32'd2);
    chk("idle_hold", 32'(state_dbg), 32'd0);
    enable = 1'b1;
    wait_state(2'd2, 40, "resume_drain_to");
    chk("resume_writes", 32'(wr_total), 32'd4);
    enable = 1'b0;
    wait_leave(2'd2, 30, "drain_end_to");
    chk("drain_to_idle", 32'(state_dbg), 32'd0);
    repeat (3) cyc();
    chk("drain_outs", 32'(out_total), 32'd4);
    chk("drain_sb_empty", 32'(out_q.size()), 32'd0);

    // Run the counter through its wrap.
    enable = 1'b1;
    wait_writes(256, 5000, "wrap_reach_to");
    chk("wrap_din255", 32'(fifo_din), 32'd255);
    chk("wrap_count0", 32'(count), 32'd0);
    wait_writes(257, 100, "wrap_next_to");
    chk("wrap_din0", 32'(fifo_din), 32'd0);
    chk("wrap_count1", 32'(count), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tick_fifo_sequencer.md
Name: tick_fifo_sequencer

Overview:
- Controller that sequences the tick-driven FIFO datapath.
- Divides clk into a periodic one-second tick and writes the running 8-bit count into an external FIFO on each tick.
- Once FILL_LEVEL words have been written, switches to draining the FIFO to the output port, then resumes filling.
- Replaces the ad-hoc rd_en/wr_en glue in top; FIFO core stays external.

Parameters:
- TICK_DIV, 50000000, clk cycles per tick (≥2); benches use 4.
- DATA_W, 8, FIFO data width and count width.
- CNT_W, 7, width of FIFO data_count input.
- FILL_LEVEL, 16, words written per burst before draining (1..FIFO depth).

Ports:
- clk  in  1  system clock, all logic rising-edge.
- reset  in  1  synchronous, active-high; clears all state.
- enable  in  1  run request; sampled every cycle.
- fifo_full  in  1  FIFO full flag.
- fifo_empty  in  1  FIFO empty flag.
- fifo_data_count  in  CNT_W  FIFO occupancy, status mirror only.
- fifo_dout  in  DATA_W  FIFO read data, valid the cycle after rd_en.
- fifo_din  out  DATA_W  FIFO write data.
- wr_en  out  1  FIFO write strobe.
- rd_en  out  1  FIFO read strobe (combinational).
- one_second_tick  out  1  one-cycle tick strobe.
- one_second_pulse  out  1  level toggling on every tick.
- count  out  DATA_W  next value to be written.
- out_data  out  DATA_W  captured FIFO word.
- out_valid  out  1  out_data valid strobe.
- state_dbg  out  2  current state encoding.
- dropped_ticks  out  8  ticks not written (optional, see below).

Behaviour:
- Reset: all registered outputs clear to 0 and state goes to IDLE.
  - Includes divider, count, burst counter, pulse, out_data, out_valid and dropped_ticks.
  - rd_en and wr_en are 0 during reset.
  - Applies in any state; a partial burst is abandoned.
  - FIFO shares the same reset and is emptied externally.
- Divider:
  - Free-runs 0..TICK_DIV-1 regardless of state or enable.
  - one_second_tick is registered high for exactly one cycle when the divider equals TICK_DIV-1.
  - First tick is on cycle TICK_DIV after reset release.
  - one_second_pulse toggles on each tick.
- States: IDLE=0, FILL=1, DRAIN=2; encoding 3 is unused and recovers to IDLE.
- IDLE:
  - wr_en=0, rd_en=0.
  - Goes to FILL the cycle after enable=1 is sampled.
- FILL, on a tick with fifo_full=0:
  - Next cycle: wr_en=1 for one cycle, fifo_din=count.
  - count increments modulo 2^DATA_W (255 wraps to 0).
  - Burst counter increments.
- FILL, on a tick with fifo_full=1:
  - No write; count is held.
  - Tick counts as dropped.
- FILL to DRAIN: the cycle after the write that makes the burst counter equal FILL_LEVEL. The burst counter then clears.
- FILL to IDLE: enable=0 in FILL returns to IDLE next cycle; the burst counter is held so the burst resumes on re-enable.
- DRAIN:
  - rd_en = (state==DRAIN) && !fifo_empty, combinational.
  - out_valid is high the cycle after each rd_en, with out_data = fifo_dout registered at that edge.
  - Ticks in DRAIN are never written; count is held and each tick counts as dropped.
- DRAIN exit:
  - Leaves when fifo_empty=1 and rd_en=0.
  - Goes to FILL if enable=1, otherwise IDLE.
  - enable=0 does not abort a drain.
- Simultaneous events:
  - A tick on the same cycle as the FILL-to-DRAIN transition is treated as a DRAIN tick (dropped).
  - The tick is never lost silently.
  - wr_en and rd_en are never high in the same cycle.
- fifo_data_count is not used for control and is only mirrored for debug.

Optional Feature:
- TICK_FIFO_DROP_CNT_EN defined:
  - dropped_ticks is an 8-bit counter incremented on each dropped tick.
  - Saturates at 255 and clears only on reset.
- Not defined: dropped_ticks is tied to 0 and no counter logic is built.

Test Plan:
- TICK_DIV=4, FILL_LEVEL=4, reset 5 cycles, enable=1:
  - tick on cycles 4, 8, 12, 16 after release.
  - wr_en pulses write 0, 1, 2, 3.
  - state reaches DRAIN after the 4th write.
- Drain (FIFO model latency 1):
  - rd_en runs 4 consecutive cycles.
  - out_valid outputs 0, 1, 2, 3.
  - Then state goes to FILL and the next write is 4.
- Full: hold fifo_full=1 across 3 ticks in FILL:
  - no wr_en and count stays constant.
  - With TICK_FIFO_DROP_CNT_EN, dropped_ticks=3.
- Wrap:
  - preload by running 256 writes.
  - count goes 255 → 0, and fifo_din=255 is followed by 0.
- Abort:
  - reset asserted mid-DRAIN with 2 words left.
  - Next cycle: state=IDLE, rd_en=0, count=0, one_second_pulse=0, out_valid=0.
- Enable:
  - enable=0 in FILL after 2 writes → IDLE.
  - Re-enable: exactly 2 more writes (2, 3) before DRAIN.
  - enable=0 during DRAIN: drain completes, then IDLE.
